// File: rtl/temp_bcd_converter.sv
// temp_bcd_converter
// Takes the raw LM75-format word from the I2C reader, waits for the 9-bit
// temperature field to settle, converts it to sign + BCD digits with an
// 8-step double-dabble, and publishes registered digits with an update pulse.
// Display drivers downstream consume digits only and never do binary math.

module temp_bcd_converter #(
  parameter int unsigned STABLE_CYCLES = 1000,  // must be >= 1
  parameter int unsigned CNT_W         = 16     // must hold STABLE_CYCLES-1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  output logic        negative,
  output logic [3:0]  bcd_hundreds,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic [3:0]  bcd_tenths,
  output logic        valid,
  output logic        update,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STABLE = 3'd1,
    S_LOAD   = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       SHIFT_LAST  = 3'd7;

  // Temperature field: 9-bit two's complement, LSB = 0.5 degC.
  logic [8:0] temp;
  assign temp = data[15:7];

  // Status/config bits of the sensor word carry no temperature information.
  logic unused_low_bits;
  assign unused_low_bits = ^data[6:0];

  // Control state
  state_e            state_q,     state_d;
  logic [8:0]        last_conv_q, last_conv_d;
  logic [8:0]        cand_q,      cand_d;
  logic [CNT_W-1:0]  stab_cnt_q,  stab_cnt_d;

  // Conversion datapath
  logic              neg_q,       neg_d;
  logic [7:0]        bin_q,       bin_d;
  logic              half_q,      half_d;
  logic [11:0]       bcd_q,       bcd_d;
  logic [2:0]        iter_q,      iter_d;

  // Published outputs
  logic              negative_q,  negative_d;
  logic [3:0]        hundreds_q,  hundreds_d;
  logic [3:0]        tens_q,      tens_d;
  logic [3:0]        ones_q,      ones_d;
  logic [3:0]        tenths_q,    tenths_d;
  logic              valid_q,     valid_d;
  logic              update_q,    update_d;
  logic              busy_q,      busy_d;

  // Magnitude of the candidate: 0..256. The -128.0 case yields 256, which
  // after dropping the half-degree bit becomes 128 and still fits 8 bits.
  logic [8:0] mag;
  assign mag = cand_q[8] ? (~cand_q + 9'd1) : cand_q;

  // One double-dabble step: correct every BCD nibble that would overflow
  // on doubling, then shift the joint {bcd, bin} register left by one.
  function automatic logic [19:0] dabble_step(input logic [11:0] bcd_in,
                                              input logic [7:0]  bin_in);
    logic [11:0] adj;
    adj = bcd_in;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj[10:0], bin_in, 1'b0};
  endfunction

  // Next-state and datapath logic for the debounce + conversion FSM.
  // NOTE: every _d is defaulted to its _q first, so paths that do not
  // assign a signal hold it instead of inferring a latch.
  always_comb begin
    state_d     = state_q;
    last_conv_d = last_conv_q;
    cand_d      = cand_q;
    stab_cnt_d  = stab_cnt_q;
    neg_d       = neg_q;
    bin_d       = bin_q;
    half_d      = half_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    negative_d  = negative_q;
    hundreds_d  = hundreds_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    tenths_d    = tenths_q;
    valid_d     = valid_q;
    update_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The first conversion after reset always runs, even for 0.0 degC.
        if (!valid_q || (temp != last_conv_q)) begin
          cand_d     = temp;
          stab_cnt_d = '0;
          state_d    = S_STABLE;
        end
      end

      S_STABLE: begin
        // Any movement restarts the count on the new value. A glitch that
        // returns to last_conv still converts; the digits just repeat.
        if (temp != cand_q) begin
          cand_d     = temp;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STABLE_LAST) begin
          state_d = S_LOAD;
        end else begin
          stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end
      end

      S_LOAD: begin
        neg_d   = cand_q[8];
        bin_d   = mag[8:1];
        half_d  = mag[0];
        bcd_d   = '0;
        iter_d  = '0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
        if (iter_q == SHIFT_LAST) begin
          state_d = S_DONE;
        end else begin
          iter_d = iter_q + 3'd1;
        end
      end

      S_DONE: begin
        hundreds_d  = bcd_q[11:8];
        tens_d      = bcd_q[7:4];
        ones_d      = bcd_q[3:0];
        tenths_d    = half_q ? 4'd5 : 4'd0;
        negative_d  = neg_q;
        last_conv_d = cand_q;
        valid_d     = 1'b1;
        update_d    = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_conv_q <= '0;
      cand_q      <= '0;
      stab_cnt_q  <= '0;
      neg_q       <= 1'b0;
      bin_q       <= '0;
      half_q      <= 1'b0;
      bcd_q       <= '0;
      iter_q      <= '0;
      negative_q  <= 1'b0;
      hundreds_q  <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      tenths_q    <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_conv_q <= last_conv_d;
      cand_q      <= cand_d;
      stab_cnt_q  <= stab_cnt_d;
      neg_q       <= neg_d;
      bin_q       <= bin_d;
      half_q      <= half_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      negative_q  <= negative_d;
      hundreds_q  <= hundreds_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      tenths_q    <= tenths_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      busy_q      <= busy_d;
    end
  end

  assign negative     = negative_q;
  assign bcd_hundreds = hundreds_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;
  assign bcd_tenths   = tenths_q;
  assign valid        = valid_q;
  assign update       = update_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Directed bench for temp_bcd_converter with STABLE_CYCLES = 4.
// Expected digits are hand-derived from the 9-bit temperature field;
// expected update latency is STABLE_CYCLES + 11 cycles after new data.

module tb_temp_bcd_converter;

  localparam int S   = 4;
  localparam int LAT = S + 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic        negative;
  logic [3:0]  bcd_hundreds;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic [3:0]  bcd_tenths;
  logic        valid;
  logic        update;
  logic        busy;

  int total = 0;
  int bad   = 0;

  temp_bcd_converter #(
    .STABLE_CYCLES(S),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .negative    (negative),
    .bcd_hundreds(bcd_hundreds),
    .bcd_tens    (bcd_tens),
    .bcd_ones    (bcd_ones),
    .bcd_tenths  (bcd_tenths),
    .valid       (valid),
    .update      (update),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // {negative, hundreds, tens, ones, tenths}
  function automatic logic [16:0] digits();
    return {negative, bcd_hundreds, bcd_tens, bcd_ones, bcd_tenths};
  endfunction

  // Drives a new word in the current cycle (cycle 0) and returns how many
  // rising edges pass until update is seen, or -1 if it never comes.
  task automatic apply_and_wait(input logic [15:0] value, output int lat);
    int k;
    data = value;
    lat  = -1;
    k    = 0;
    while (lat < 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (update === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1;
    data  = 16'h1900;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({digits(), valid, update, busy} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 00000", {digits(), valid, update, busy});
    end
    reset = 1'b0;
    apply_and_wait(16'h1900, lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL first_conv_latency: got %0d expected %0d", lat, LAT);
    end
    total++;
    if (digits() !== {1'b0, 4'd0, 4'd2, 4'd5, 4'd0}) begin
      bad++;
      $display("FAIL first_conv_digits: got %h expected %h", digits(), {1'b0, 4'd0, 4'd2, 4'd5, 4'd0});
    end
    total++;
    if ({valid, busy} !== 2'b10) begin
      bad++;
      $display("FAIL first_conv_valid_busy: got %b expected 10", {valid, busy});
    end
    @(posedge clk); #1;
    total++;
    if ({update, valid, busy} !== 3'b010) begin
      bad++;
      $display("FAIL update_one_cycle: got upd/valid/busy=%b expected 010", {update, valid, busy});
    end
    total++;
    if (digits() !== {1'b0, 4'd0, 4'd2, 4'd5, 4'd0}) begin
      bad++;
      $display("FAIL digits_hold: got %h expected %h", digits(), {1'b0, 4'd0, 4'd2, 4'd5, 4'd0});
    end
  endtask

  task automatic test_sign_and_half();
    logic [15:0] vecs [3];
    logic [16:0] exps [3];
    int lat;
    vecs[0] = 16'hE700; exps[0] = {1'b1, 4'd0, 4'd2, 4'd5, 4'd0};  // -25.0
    vecs[1] = 16'h1980; exps[1] = {1'b0, 4'd0, 4'd2, 4'd5, 4'd5};  //  25.5
    vecs[2] = 16'hFF80; exps[2] = {1'b1, 4'd0, 4'd0, 4'd0, 4'd5};  //  -0.5
    for (int i = 0; i < 3; i++) begin
      apply_and_wait(vecs[i], lat);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL sign_latency[%h]: got %0d expected %0d", vecs[i], lat, LAT);
      end
      total++;
      if (digits() !== exps[i]) begin
        bad++;
        $display("FAIL sign_digits[%h]: got %h expected %h", vecs[i], digits(), exps[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] vecs [3];
    logic [16:0] exps [3];
    int lat;
    vecs[0] = 16'h7D00; exps[0] = {1'b0, 4'd1, 4'd2, 4'd5, 4'd0};  //  125.0
    vecs[1] = 16'h8000; exps[1] = {1'b1, 4'd1, 4'd2, 4'd8, 4'd0};  // -128.0
    vecs[2] = 16'h7F80; exps[2] = {1'b0, 4'd1, 4'd2, 4'd7, 4'd5};  //  127.5
    for (int i = 0; i < 3; i++) begin
      apply_and_wait(vecs[i], lat);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL extreme_latency[%h]: got %0d expected %0d", vecs[i], lat, LAT);
      end
      total++;
      if (digits() !== exps[i]) begin
        bad++;
        $display("FAIL extreme_digits[%h]: got %h expected %h", vecs[i], digits(), exps[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int lat;
    int n_upd;
    int n_bad_digits;
    bit seen_busy;
    logic [16:0] exp_d;
    exp_d = {1'b0, 4'd0, 4'd2, 4'd5, 4'd0};
    apply_and_wait(16'h1900, lat);
    total++;
    if (digits() !== exp_d) begin
      bad++;
      $display("FAIL glitch_setup: got %h expected %h", digits(), exp_d);
    end
    n_upd        = 0;
    n_bad_digits = 0;
    seen_busy    = 1'b0;
    data = 16'h1A00;
    for (int k = 0; k < 42; k++) begin
      if (k == 2) data = 16'h1900;
      @(posedge clk); #1;
      if (busy === 1'b1) seen_busy = 1'b1;
      if (update === 1'b1) n_upd++;
      if (digits() !== exp_d) n_bad_digits++;
    end
    total++;
    if (seen_busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy: got %b expected 1", seen_busy);
    end
    total++;
    if (n_upd !== 1) begin
      bad++;
      $display("FAIL glitch_update_count: got %0d expected 1", n_upd);
    end
    total++;
    if (n_bad_digits !== 0) begin
      bad++;
      $display("FAIL glitch_digits: got %0d off-value cycles expected 0", n_bad_digits);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_settle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_ignored_bits();
    int n_busy;
    int n_upd;
    n_busy = 0;
    n_upd  = 0;
    data   = 16'h197F;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) n_busy++;
      if (update === 1'b1) n_upd++;
    end
    total++;
    if (n_busy !== 0) begin
      bad++;
      $display("FAIL ignored_busy: got %0d busy cycles expected 0", n_busy);
    end
    total++;
    if (n_upd !== 0) begin
      bad++;
      $display("FAIL ignored_update: got %0d updates expected 0", n_upd);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    data = 16'h8000;
    repeat (S + 4) @(posedge clk);
    #1;
    total++;
    if ({busy, update} !== 2'b10) begin
      bad++;
      $display("FAIL midshift_busy: got busy/upd=%b expected 10", {busy, update});
    end
    reset = 1'b1;
    data  = 16'h1900;
    @(posedge clk); #1;
    total++;
    if ({digits(), valid, update, busy} !== 20'h0) begin
      bad++;
      $display("FAIL midshift_reset_outputs: got %h expected 00000", {digits(), valid, update, busy});
    end
    reset = 1'b0;
    apply_and_wait(16'h1900, lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL rerun_latency: got %0d expected %0d", lat, LAT);
    end
    total++;
    if ({digits(), valid} !== {1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL rerun_digits: got %h expected %h", {digits(), valid}, {1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 1'b1});
    end
  endtask

  initial begin
    reset = 1'b1;
    data  = 16'h0000;
    @(posedge clk); #1;
    test_reset();
    test_sign_and_half();
    test_extremes();
    test_glitch();
    test_ignored_bits();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
